cd_sector_fifo: RTL and testbench

//  Buffers CD sector payload words streamed from the HPS bridge (cd_data_out / cdctl_wr / cd_dat_download).

---
 rtl/cd_sector_fifo_if.sv | 31 +++
 rtl/cd_sector_fifo.sv | 160 ++++++++++++++++
 tb/tb_cd_sector_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cd_sector_fifo_if.sv
// cd_sector_fifo_if: producer/consumer bundle for the CD sector FIFO.
// master = bridge/controller side, slave = FIFO side.
interface cd_sector_fifo_if #(
    parameter int DEPTH = 1024
);
    logic                     flush;
    logic [15:0]              wr_data;
    logic                     wr_en;
    logic                     dl_active;
    logic [7:0]               rd_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic                     almost_full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   level;
    logic                     sector_done;
    logic                     overflow;
    logic [15:0]              drop_cnt;

    modport master (
        output flush, wr_data, wr_en, dl_active, rd_ready,
        input  rd_data, rd_valid, almost_full, empty, level,
        input  sector_done, overflow, drop_cnt
    );

    modport slave (
        input  flush, wr_data, wr_en, dl_active, rd_ready,
        output rd_data, rd_valid, almost_full, empty, level,
        output sector_done, overflow, drop_cnt
    );
endinterface

// File: rtl/cd_sector_fifo.sv
// cd_sector_fifo: CD sector word FIFO, byte-serial output, sector tracking.
// Define CDFIFO_STATS_EN to build the saturating dropped-write counter.
module cd_sector_fifo #(
    parameter int DEPTH        = 1024,
    parameter int AF_MARGIN    = 64,
    parameter int SECTOR_WORDS = 1176
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    cd_sector_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(SECTOR_WORDS);
    localparam logic [LW-1:0] L_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] L_AF   = LW'(DEPTH - AF_MARGIN);
    localparam logic [SW-1:0] S_LAST = SW'(SECTOR_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI
    } stg_t;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [15:0]   r_q;
    logic          r_qv;
    logic [15:0]   r_word;
    stg_t          r_st;
    stg_t          w_st_nxt;
    logic [SW-1:0] r_sec;
    logic          r_done;
    logic          r_ovf;

    logic w_full;
    logic w_wr;
    logic w_drop;
    logic w_load;
    logic w_pop;

    assign w_full = (r_level == L_FULL);
    assign w_wr   = bus.wr_en & ~w_full & ~bus.flush;
    assign w_drop = bus.wr_en & w_full & ~bus.flush;
    assign w_pop  = (r_level != '0) & (~r_qv | w_load) & ~bus.flush;

    // r_q is the RAM read register; it feeds the byte stage without a bubble
    always_comb begin
        w_st_nxt = r_st;
        w_load   = 1'b0;
        unique case (r_st)
            ST_IDLE: begin
                if (r_qv) begin
                    w_load   = 1'b1;
                    w_st_nxt = ST_LO;
                end
            end
            ST_LO: begin
                if (bus.rd_ready) w_st_nxt = ST_HI;
            end
            ST_HI: begin
                if (bus.rd_ready) begin
                    w_load   = r_qv;
                    w_st_nxt = r_qv ? ST_LO : ST_IDLE;
                end
            end
            default: w_st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (w_wr) r_mem[r_wptr] <= bus.wr_data;
        if (w_pop) r_q <= r_mem[r_rptr];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_qv    <= 1'b0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_qv    <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_wr & ~w_pop) r_level <= r_level + 1'b1;
            else if (~w_wr & w_pop) r_level <= r_level - 1'b1;
            if (w_pop) r_qv <= 1'b1;
            else if (w_load) r_qv <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_st   <= ST_IDLE;
            r_word <= '0;
        end else if (bus.flush) begin
            r_st   <= ST_IDLE;
            r_word <= '0;
        end else begin
            r_st <= w_st_nxt;
            if (w_load) r_word <= r_q;
        end
    end

    // a falling dl_active discards any partial sector count
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sec  <= '0;
            r_done <= 1'b0;
        end else if (bus.flush || !bus.dl_active) begin
            r_sec  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wr) begin
                if (r_sec == S_LAST) begin
                    r_sec  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_sec <= r_sec + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_ovf <= 1'b0;
        else if (bus.flush) r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
    end

`ifdef CDFIFO_STATS_EN
    logic [15:0] r_drop;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_drop <= '0;
        else if (bus.flush) r_drop <= '0;
        else if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
    end

    assign bus.drop_cnt = r_drop;
`else
    assign bus.drop_cnt = 16'h0000;
`endif

    assign bus.rd_valid    = (r_st != ST_IDLE);
    assign bus.rd_data     = (r_st == ST_HI) ? r_word[15:8] : r_word[7:0];
    assign bus.level       = r_level;
    assign bus.almost_full = (r_level >= L_AF);
    assign bus.empty       = (r_level == '0) & ~r_qv & (r_st == ST_IDLE);
    assign bus.sector_done = r_done;
    assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_cd_sector_fifo.sv
// tb_cd_sector_fifo: vector table, directed corner sequences and a
// randomized byte-stream check against a queue model.
module tb_cd_sector_fifo;
    localparam int DEPTH = 1024;
    localparam int AFM   = 64;
    localparam int SECW  = 1176;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    cd_sector_fifo_if #(.DEPTH(DEPTH)) bus();

    cd_sector_fifo #(
        .DEPTH(DEPTH),
        .AF_MARGIN(AFM),
        .SECTOR_WORDS(SECW)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wr;
        logic [15:0] d;
        logic        rdy;
        logic        v;
        logic [7:0]  b;
        int          lvl;
        logic        emp;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic wr1(input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b1;
        while (!bus.empty && t < 5000) begin
            tick();
            t++;
        end
        chk(nm, 32'(bus.empty), 32'd1);
    endtask

    logic [7:0] bq[$];
    int pulses, at_k, t, wrote, bytes_out, outst, lv;
    logic rdy, we, ok;
    logic [15:0] d;
    logic [7:0] eb;
    logic [15:0] exp_drop3, exp_drop5;

    initial begin
        tv[0]  = '{1'b1, 16'hA55A, 1'b1, 1'b0, 8'h00, 1, 1'b0};
        tv[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 0, 1'b0};
        tv[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h5A, 0, 1'b0};
        tv[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hA5, 0, 1'b0};
        tv[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 0, 1'b1};
        tv[5]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 8'h00, 1, 1'b0};
        tv[6]  = '{1'b1, 16'h5678, 1'b1, 1'b0, 8'h00, 1, 1'b0};
        tv[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h34, 0, 1'b0};
        tv[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h12, 0, 1'b0};
        tv[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h78, 0, 1'b0};
        tv[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h56, 0, 1'b0};
        tv[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 0, 1'b1};
        tv[12] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00, 1, 1'b0};
        tv[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        tv[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 0, 1'b0};
        tv[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 0, 1'b0};
        tv[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hBE, 0, 1'b0};
        tv[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 0, 1'b1};

`ifdef CDFIFO_STATS_EN
        exp_drop3 = 16'd3;
        exp_drop5 = 16'd5;
`else
        exp_drop3 = 16'd0;
        exp_drop5 = 16'd0;
`endif

        bus.flush     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.dl_active = 1'b0;
        bus.rd_ready  = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst.valid", 32'(bus.rd_valid), 32'd0);
        chk("rst.data", 32'(bus.rd_data), 32'd0);
        chk("rst.empty", 32'(bus.empty), 32'd1);
        chk("rst.af", 32'(bus.almost_full), 32'd0);
        chk("rst.level", 32'(bus.level), 32'd0);
        chk("rst.ovf", 32'(bus.overflow), 32'd0);
        chk("rst.drop", 32'(bus.drop_cnt), 32'd0);
        chk("rst.done", 32'(bus.sector_done), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        tick();

        // vector table: latency, byte order, no bubble, stall stability
        for (int i = 0; i < 18; i++) begin
            bus.wr_en    = tv[i].wr;
            bus.wr_data  = tv[i].d;
            bus.rd_ready = tv[i].rdy;
            tick();
            chk($sformatf("vec%0d.valid", i), 32'(bus.rd_valid), 32'(tv[i].v));
            if (tv[i].v)
                chk($sformatf("vec%0d.data", i), 32'(bus.rd_data), 32'(tv[i].b));
            chk($sformatf("vec%0d.level", i), 32'(bus.level), 32'(tv[i].lvl));
            chk($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(tv[i].emp));
        end
        bus.wr_en = 1'b0;

        // fill: almost_full threshold, full, drops
        do_flush();
        bus.rd_ready = 1'b0;
        wr1(16'hF000);
        wr1(16'hF001);
        tick();
        tick();
        tick();
        chk("fill.level0", 32'(bus.level), 32'd0);
        chk("fill.valid", 32'(bus.rd_valid), 32'd1);
        for (int k = 1; k <= DEPTH; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(k);
            tick();
            if (k == DEPTH - AFM - 1)
                chk("fill.af_below", 32'(bus.almost_full), 32'd0);
            if (k == DEPTH - AFM) begin
                chk("fill.af_rise", 32'(bus.almost_full), 32'd1);
                chk("fill.af_level", 32'(bus.level), 32'(DEPTH - AFM));
            end
        end
        chk("fill.full", 32'(bus.level), 32'(DEPTH));
        chk("fill.ovf0", 32'(bus.overflow), 32'd0);
        tick();
        tick();
        tick();
        bus.wr_en = 1'b0;
        chk("drop.level", 32'(bus.level), 32'(DEPTH));
        chk("drop.ovf", 32'(bus.overflow), 32'd1);
        chk("drop.cnt3", 32'(bus.drop_cnt), 32'(exp_drop3));
        bus.wr_en    = 1'b1;
        bus.rd_ready = 1'b1;
        tick();
        tick();
        bus.wr_en = 1'b0;
        chk("drop.popfull", 32'(bus.level), 32'(DEPTH - 1));
        chk("drop.cnt5", 32'(bus.drop_cnt), 32'(exp_drop5));
        chk("drop.valid", 32'(bus.rd_valid), 32'd1);
        do_flush();
        chk("flush.valid", 32'(bus.rd_valid), 32'd0);
        chk("flush.level", 32'(bus.level), 32'd0);
        chk("flush.ovf", 32'(bus.overflow), 32'd0);
        chk("flush.empty", 32'(bus.empty), 32'd1);
        chk("flush.af", 32'(bus.almost_full), 32'd0);
        chk("flush.drop", 32'(bus.drop_cnt), 32'd0);

        // simultaneous write and pop at level 5
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 2; k++) wr1(16'hC3A0 + 16'(k));
        tick();
        tick();
        tick();
        for (int k = 2; k < 7; k++) wr1(16'hC3A0 + 16'(k));
        chk("wp.level5", 32'(bus.level), 32'd5);
        chk("wp.lo", 32'(bus.rd_data), 32'h0A0);
        bus.rd_ready = 1'b1;
        tick();
        chk("wp.hi", 32'(bus.rd_data), 32'h0C3);
        wr1(16'hC3A7);
        chk("wp.level", 32'(bus.level), 32'd5);
        chk("wp.next", 32'(bus.rd_data), 32'h0A1);
        drain("wp.drain");

        // sector boundary
        do_flush();
        bus.rd_ready  = 1'b1;
        bus.dl_active = 1'b1;
        pulses = 0;
        at_k   = 0;
        for (int k = 1; k <= SECW; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(k);
            tick();
            if (bus.sector_done) begin
                pulses++;
                at_k = k;
            end
        end
        bus.wr_en = 1'b0;
        chk("sec.pulses", 32'(pulses), 32'd1);
        chk("sec.at", 32'(at_k), 32'(SECW));
        tick();
        chk("sec.onecyc", 32'(bus.sector_done), 32'd0);
        drain("sec.drain1");
        pulses = 0;
        for (int k = 1; k < SECW; k++) begin
            bus.wr_en = 1'b1;
            tick();
            if (bus.sector_done) pulses++;
        end
        bus.wr_en     = 1'b0;
        bus.dl_active = 1'b0;
        tick();
        chk("sec.nofall", 32'(bus.sector_done), 32'd0);
        bus.dl_active = 1'b1;
        drain("sec.drain2");
        at_k = 0;
        for (int k = 1; k <= SECW; k++) begin
            bus.wr_en = 1'b1;
            tick();
            if (bus.sector_done) begin
                pulses++;
                at_k = k;
            end
        end
        bus.wr_en     = 1'b0;
        bus.dl_active = 1'b0;
        chk("sec.restart_pulses", 32'(pulses), 32'd1);
        chk("sec.restart_at", 32'(at_k), 32'(SECW));
        drain("sec.drain3");

        // randomized stream against a byte queue
        do_flush();
        bq.delete();
        wrote     = 0;
        bytes_out = 0;
        for (int c = 0; c < 3000; c++) begin
            outst = wrote - bytes_out / 2;
            lv    = int'(bus.level);
            ok    = (lv <= outst) && (lv >= outst - 2);
            chk("rnd.level", 32'(ok), 32'd1);
            rdy = ($urandom_range(0, 9) < 7);
            we  = ($urandom_range(0, 9) < 4);
            d   = 16'($urandom);
            if (bus.rd_valid && rdy) begin
                eb = (bq.size() > 0) ? bq.pop_front() : 8'hXX;
                chk("rnd.byte", 32'(bus.rd_data), 32'(eb));
                bytes_out++;
            end
            if (we) begin
                bq.push_back(d[7:0]);
                bq.push_back(d[15:8]);
                wrote++;
            end
            bus.rd_ready = rdy;
            bus.wr_en    = we;
            bus.wr_data  = d;
            tick();
        end
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b1;
        t = 0;
        while (bq.size() > 0 && t < 5000) begin
            if (bus.rd_valid) begin
                eb = bq.pop_front();
                chk("rnd.tail", 32'(bus.rd_data), 32'(eb));
            end
            tick();
            t++;
        end
        chk("rnd.left", 32'(bq.size()), 32'd0);
        chk("rnd.empty", 32'(bus.empty), 32'd1);
        chk("rnd.ovf", 32'(bus.overflow), 32'd0);

        // async reset with high byte pending
        bus.rd_ready = 1'b0;
        wr1(16'h9C3E);
        wr1(16'h1111);
        wr1(16'h2222);
        tick();
        tick();
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("ar.pending", 32'(bus.rd_data), 32'h09C);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar.valid", 32'(bus.rd_valid), 32'd0);
        chk("ar.data", 32'(bus.rd_data), 32'd0);
        chk("ar.level", 32'(bus.level), 32'd0);
        chk("ar.empty", 32'(bus.empty), 32'd1);
        chk("ar.af", 32'(bus.almost_full), 32'd0);
        chk("ar.done", 32'(bus.sector_done), 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        chk("ar.after", 32'(bus.empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
